// File: rtl/ulbf_dout_capture.sv
// ulbf_dout_capture: captures a block of AXI-Stream beats into a RAM write
// port. A one-cycle start samples a base address and a block length, then
// every accepted beat is written to consecutive (wrapping) RAM addresses until
// the block completes, tlast arrives early, or the capture is aborted.
module ulbf_dout_capture #(
  parameter int RAM_DEPTH  = 4096,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    s_axis_clk,
  input  logic                    s_axis_rstn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic                    start,
  input  logic [15:0]             base_addr,
  input  logic [15:0]             block_len,
  input  logic                    abort,
  output logic [15:0]             ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic                    busy,
  output logic                    done,
  output logic                    err_tlast_early,
  output logic                    err_tlast_missing,
  output logic [15:0]             beat_count
);

  localparam int WE_W = DATA_WIDTH / 8;
  // Highest RAM address, which is also the final beat index of a full-depth block.
  localparam logic [15:0] TOP_INDEX = 16'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t                  r_state;
  logic [15:0]             r_nextAddr;
  logic [15:0]             r_lastIdx;
  logic [15:0]             r_beatCount;
  logic                    r_errEarly;
  logic                    r_errMissing;
  logic                    r_ramEn;
  logic [15:0]             r_ramAddr;
  logic [DATA_WIDTH-1:0]   r_ramDin;

  logic                    w_beat;
  logic                    w_finalBeat;
  logic [15:0]             w_startAddr;
  logic [15:0]             w_startLastIdx;
  logic [15:0]             w_addrInc;
  logic                    w_ramEnOut;

  // Ready is a pure decode of the state register, so a beat is accepted
  // whenever the FSM is capturing and the source presents valid data.
  assign w_beat         = (r_state == CAPTURE) && s_axis_tvalid;
  assign w_finalBeat    = (r_beatCount == r_lastIdx);
  // Base address is folded into the RAM range once, at start.
  assign w_startAddr    = 16'(32'(base_addr) % 32'(RAM_DEPTH));
  // A zero length requests a full-depth block.
  assign w_startLastIdx = (block_len == 16'd0) ? TOP_INDEX : (block_len - 16'd1);
  assign w_addrInc      = (r_nextAddr == TOP_INDEX) ? 16'd0 : (r_nextAddr + 16'd1);

  // Control FSM: sequencing, beat counting, address stepping and error flags.
  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_rstn) begin
      r_state      <= IDLE;
      r_nextAddr   <= 16'd0;
      r_lastIdx    <= 16'd0;
      r_beatCount  <= 16'd0;
      r_errEarly   <= 1'b0;
      r_errMissing <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= CAPTURE;
            r_nextAddr   <= w_startAddr;
            r_lastIdx    <= w_startLastIdx;
            r_beatCount  <= 16'd0;
            r_errEarly   <= 1'b0;
            r_errMissing <= 1'b0;
          end
        end
        CAPTURE: begin
          if (w_beat) begin
            r_nextAddr  <= w_addrInc;
            r_beatCount <= r_beatCount + 16'd1;
            if (w_finalBeat) begin
              r_state <= DONE;
              if (!s_axis_tlast) begin
                r_errMissing <= 1'b1;
              end
            end else if (s_axis_tlast) begin
              r_state    <= DONE;
              r_errEarly <= 1'b1;
            end
          end
          if (abort) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // RAM write port register: one write in the cycle after each accepted beat.
  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_rstn) begin
      r_ramEn   <= 1'b0;
      r_ramAddr <= 16'd0;
      r_ramDin  <= '0;
    end else if (w_beat) begin
      r_ramEn   <= 1'b1;
      r_ramAddr <= r_nextAddr;
      r_ramDin  <= s_axis_tdata;
    end else begin
      r_ramEn   <= 1'b0;
    end
  end

  // A write already registered when reset arrives must not reach the RAM,
  // so the enable is qualified by the reset input itself.
  assign w_ramEnOut        = r_ramEn & s_axis_rstn;

  assign s_axis_tready     = (r_state == CAPTURE);
  assign busy              = (r_state != IDLE);
  assign done              = (r_state == DONE);
  assign ram_en            = w_ramEnOut;
  assign ram_we            = {WE_W{w_ramEnOut}};
  assign ram_addr          = r_ramAddr;
  assign ram_din           = r_ramDin;
  assign beat_count        = r_beatCount;
  assign err_tlast_early   = r_errEarly;
  assign err_tlast_missing = r_errMissing;

endmodule

// File: tb/tb_ulbf_dout_capture.sv
// Testbench for ulbf_dout_capture: directed scenarios plus randomized blocks,
// each cycle compared against a block-level reference model of the capture.
module tb_ulbf_dout_capture;

  localparam int D = 4096;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rstn;
  logic [W-1:0]   tdata;
  logic           tvalid;
  logic           tlast;
  logic           tready;
  logic           start;
  logic [15:0]    baseAddr;
  logic [15:0]    blockLen;
  logic           abortIn;
  logic [15:0]    ramAddr;
  logic [W-1:0]   ramDin;
  logic           ramEn;
  logic [W/8-1:0] ramWe;
  logic           busy;
  logic           done;
  logic           errEarly;
  logic           errMissing;
  logic [15:0]    beatCount;

  int cmpCount  = 0;
  int failCount = 0;

  // Reference model: phase 0 = idle, 1 = capturing, 2 = done pulse.
  int          mPhase = 0;
  int          mBase  = 0;
  int          mLen   = 0;
  int          mBeat  = 0;
  bit          mErrE  = 0;
  bit          mErrM  = 0;
  bit          expEn  = 0;
  int          expAddr = 0;
  logic [63:0] expDin  = '0;

  always #5 clk = ~clk;

  ulbf_dout_capture #(.RAM_DEPTH(D), .DATA_WIDTH(W)) dut (
    .s_axis_clk       (clk),
    .s_axis_rstn      (rstn),
    .s_axis_tdata     (tdata),
    .s_axis_tvalid    (tvalid),
    .s_axis_tlast     (tlast),
    .s_axis_tready    (tready),
    .start            (start),
    .base_addr        (baseAddr),
    .block_len        (blockLen),
    .abort            (abortIn),
    .ram_addr         (ramAddr),
    .ram_din          (ramDin),
    .ram_en           (ramEn),
    .ram_we           (ramWe),
    .busy             (busy),
    .done             (done),
    .err_tlast_early  (errEarly),
    .err_tlast_missing(errMissing),
    .beat_count       (beatCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the clock and update the model.
  task automatic applyStimulus(input bit st, input logic [15:0] ba, input logic [15:0] bl,
                               input bit v, input bit l, input bit ab, input bit rst);
    logic [63:0] d;
    d        = {$urandom, $urandom};
    rstn     = rst;
    start    = st;
    baseAddr = ba;
    blockLen = bl;
    tvalid   = v;
    tlast    = l;
    abortIn  = ab;
    tdata    = d;
    if (!rst) begin
      #1;
      chk("ram_en_during_reset", ramEn, 1'b0);
      chk("ram_we_during_reset", ramWe, 8'h00);
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      mPhase = 0; mBeat = 0; mErrE = 0; mErrM = 0;
      expEn = 0; expAddr = 0; expDin = '0;
    end else begin
      case (mPhase)
        0: begin
          expEn = 0;
          if (st) begin
            mPhase = 1;
            mBase  = ba % D;
            mLen   = (bl == 16'd0) ? D : int'(bl);
            mBeat  = 0; mErrE = 0; mErrM = 0;
          end
        end
        1: begin
          expEn = 0;
          if (v) begin
            expEn   = 1;
            expAddr = (mBase + mBeat) % D;
            expDin  = d;
            mBeat++;
            if (mBeat == mLen) begin
              mPhase = 2;
              if (!l) mErrM = 1;
            end else if (l) begin
              mPhase = 2;
              mErrE  = 1;
            end
          end
          if (ab) mPhase = 2;
        end
        default: begin
          expEn  = 0;
          mPhase = 0;
        end
      endcase
    end
  endtask

  task automatic checkOutput();
    chk("tready",     tready,     mPhase == 1);
    chk("busy",       busy,       mPhase != 0);
    chk("done",       done,       mPhase == 2);
    chk("beat_count", beatCount,  mBeat);
    chk("err_early",  errEarly,   mErrE);
    chk("err_missing",errMissing, mErrM);
    chk("ram_en",     ramEn,      expEn);
    chk("ram_we",     ramWe,      expEn ? 8'hFF : 8'h00);
    chk("ram_addr",   ramAddr,    expAddr);
    chk("ram_din",    ramDin,     expDin);
  endtask

  task automatic step(input bit st, input logic [15:0] ba, input logic [15:0] bl,
                      input bit v, input bit l, input bit ab, input bit rst);
    applyStimulus(st, ba, bl, v, l, ab, rst);
    checkOutput();
  endtask

  task automatic startBlock(input logic [15:0] ba, input logic [15:0] bl);
    step(1'b1, ba, bl, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic beat(input bit v, input bit l, input bit ab);
    step(1'b0, 16'h0, 16'h0, v, l, ab, 1'b1);
  endtask

  task automatic drainToIdle(input int limit);
    int n;
    n = 0;
    while (mPhase != 0 && n < limit) begin
      beat($urandom_range(0, 3) != 0, 1'b0, 1'b0);
      n++;
    end
    cmpCount++;
    assert (mPhase == 0) else begin
      failCount++;
      $error("[TB] FAIL drain_timeout: observed phase %0d expected 0", mPhase);
    end
  endtask

  initial begin
    int wrapAddr[4];
    wrapAddr = '{4094, 4095, 0, 1};

    // Reset state
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);

    // Back-to-back block of 8 at 0x10 with correct tlast
    $display("[TB] block of 8 at 0x10");
    startBlock(16'h0010, 16'd8);
    for (int k = 0; k < 8; k++) beat(1'b1, k == 7, 1'b0);
    chk("done_after_8", done, 1'b1);
    chk("count_after_8", beatCount, 16'd8);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);

    // Address wrap across the top of the RAM
    $display("[TB] wrap block at 4094");
    startBlock(16'd4094, 16'd4);
    for (int k = 0; k < 4; k++) begin
      beat(1'b1, k == 3, 1'b0);
      chk("wrap_addr", ramAddr, 64'(wrapAddr[k]));
    end
    beat(1'b0, 1'b0, 1'b0);

    // Early tlast, start ignored in DONE, then a new start clears the flag
    $display("[TB] early tlast");
    startBlock(16'h0100, 16'd6);
    for (int k = 0; k < 3; k++) beat(1'b1, k == 2, 1'b0);
    chk("early_flag", errEarly, 1'b1);
    step(1'b1, 16'h0123, 16'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    startBlock(16'h0500, 16'd2);
    chk("early_cleared", errEarly, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);

    // Missing tlast with tvalid toggling
    $display("[TB] missing tlast, toggling valid");
    startBlock(16'h0200, 16'd4);
    for (int i = 0; i < 9; i++) beat(i % 2 == 0, 1'b0, 1'b0);
    chk("missing_flag", errMissing, 1'b1);

    // Abort after three beats
    $display("[TB] abort");
    startBlock(16'h0300, 16'd10);
    for (int k = 0; k < 3; k++) beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b1);
    chk("abort_done", done, 1'b1);
    chk("abort_count", beatCount, 16'd3);
    beat(1'b1, 1'b0, 1'b0);

    // Reset mid-block with a write pending
    $display("[TB] reset mid-block");
    startBlock(16'h0400, 16'd10);
    for (int k = 0; k < 3; k++) beat(1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_tready", tready, 1'b0);
    beat(1'b1, 1'b0, 1'b0);

    // Full-depth block (len 0) with a start issued mid-capture
    $display("[TB] full depth block");
    startBlock(16'h0007, 16'd0);
    for (int k = 0; k < D; k++) begin
      if (k == 100) step(1'b1, 16'h0005, 16'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      else          beat(1'b1, k == D - 1, 1'b0);
    end
    chk("full_done", done, 1'b1);
    beat(1'b0, 1'b0, 1'b0);

    // Randomized blocks
    $display("[TB] random blocks");
    for (int b = 0; b < 25; b++) begin
      int n;
      startBlock(16'($urandom_range(0, D - 1)), 16'($urandom_range(1, 24)));
      n = 0;
      while (mPhase == 1 && n < 200) begin
        bit v, l, ab;
        v  = $urandom_range(0, 3) != 0;
        l  = (mBeat == mLen - 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
        ab = $urandom_range(0, 31) == 0;
        if (ab) l = 1'b0;
        beat(v, l, ab);
        n++;
      end
      drainToIdle(10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
